// File: rtl/spi_slave_regwrite_if.sv
// SPI pins plus the register-write port of the SPI write slave.
// The slave modport is the DUT view; master drives SPI and observes writes.
interface spi_slave_regwrite_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cs;
    logic              sclk;
    logic              sdata;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              err;
    logic              busy;

    modport master (
        output cs, sclk, sdata,
        input  we, waddr, wdata, err, busy
    );

    modport slave (
        input  cs, sclk, sdata,
        output we, waddr, wdata, err, busy
    );
endinterface

// File: rtl/spi_slave_regwrite.sv
// SPI write-only slave: oversampled CS/SCLK/SDATA, LSB-first addr+data frame,
// issued as a one-cycle register write strobe (or an error pulse on a bad length).
module spi_slave_regwrite #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8
) (
    input logic                 clk,
    input logic                 rst,
    spi_slave_regwrite_if.slave bus
);
    localparam int          FRAME     = ADDR_W + DATA_W;
    localparam logic [4:0]  FRAME_CNT = 5'(FRAME);

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sd_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   cs_s, sclk_s, sd_s;
    logic                   cs_d, sclk_d, sd_d;
    logic                   armed;
    logic                   cs_fall, cs_rise, sclk_rise;

    state_t                 state;
    logic [4:0]             cnt;
    logic [FRAME-1:0]       sr;
    logic                   we, err;
    logic [ADDR_W-1:0]      waddr;
    logic [DATA_W-1:0]      wdata;

    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sd_s   = sd_sync[SYNC_STAGES-1];

    // armed blocks the fake CS fall seen when CS is held low across reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            sd_sync   <= '0;
            fill      <= '0;
            cs_d      <= 1'b1;
            sclk_d    <= 1'b0;
            sd_d      <= 1'b0;
            armed     <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
            sclk_rise <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
            sd_sync   <= {sd_sync[SYNC_STAGES-2:0], bus.sdata};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            cs_d      <= cs_s;
            sclk_d    <= sclk_s;
            sd_d      <= sd_s;
            armed     <= armed | (fill[SYNC_STAGES-1] & cs_s);
            cs_fall   <= armed & cs_d & ~cs_s;
            cs_rise   <= ~cs_d & cs_s;
            sclk_rise <= ~sclk_d & sclk_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sr    <= '0;
            we    <= 1'b0;
            err   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we  <= 1'b0;
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall) begin
                        cnt   <= '0;
                        sr    <= '0;
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state <= IDLE;
                        if (cnt == FRAME_CNT) begin
                            waddr <= sr[ADDR_W-1:0];
                            wdata <= sr[FRAME-1:ADDR_W];
                            we    <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        sr <= {sd_d, sr[FRAME-1:1]};
                        if (cnt != 5'd31) cnt <= cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.we    = we;
    assign bus.err   = err;
    assign bus.waddr = waddr;
    assign bus.wdata = wdata;
    assign bus.busy  = (state == ACTIVE);
endmodule

// File: tb/tb_spi_slave_regwrite.sv
// Bench for spi_slave_regwrite: directed cases plus random frames against
// a frame-level model (16 bits -> write of low/high byte, else error).
module tb_spi_slave_regwrite;
    logic clk = 1'b0;
    logic rst = 1'b1;

    spi_slave_regwrite_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    spi_slave_regwrite #(
        .SYNC_STAGES(2),
        .ADDR_W(8),
        .DATA_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int we_cnt = 0, err_cnt = 0, we_wide = 0, err_wide = 0;
    logic we_q = 1'b0, err_q = 1'b0, busy_seen = 1'b0;

    int exp_we = 0, exp_err = 0;
    logic [7:0] exp_addr = 8'h00, exp_data = 8'h00;

    always @(negedge clk) begin
        if (bus.we) begin
            we_cnt++;
            if (we_q) we_wide++;
        end
        if (bus.err) begin
            err_cnt++;
            if (err_q) err_wide++;
        end
        if (bus.busy) busy_seen = 1'b1;
        we_q  = bus.we;
        err_q = bus.err;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input int n, input logic [63:0] bits);
        for (int i = 0; i < n; i++) begin
            bus.sdata = bits[i];
            #500 bus.sclk = 1'b1;
            #500 bus.sclk = 1'b0;
        end
    endtask

    task automatic model_frame(input int n, input logic [63:0] bits);
        if (n == 16) begin
            exp_we++;
            exp_addr = bits[7:0];
            exp_data = bits[15:8];
        end else begin
            exp_err++;
        end
    endtask

    task automatic spi_frame(input int n, input logic [63:0] bits);
        bus.cs = 1'b0;
        #500;
        send_bits(n, bits);
        #500 bus.cs = 1'b1;
        bus.sdata = 1'b0;
        #1000;
        model_frame(n, bits);
    endtask

    task automatic check_outs(input string tag);
        check({tag, ".we_cnt"}, we_cnt, exp_we);
        check({tag, ".err_cnt"}, err_cnt, exp_err);
        check({tag, ".waddr"}, {24'h0, bus.waddr}, {24'h0, exp_addr});
        check({tag, ".wdata"}, {24'h0, bus.wdata}, {24'h0, exp_data});
    endtask

    initial begin
        int n, lat;
        logic busy_pre;
        logic [63:0] bits;

        bus.cs = 1'b1;
        bus.sclk = 1'b0;
        bus.sdata = 1'b0;
        #55;
        check("rst.we", bus.we, 0);
        check("rst.err", bus.err, 0);
        check("rst.busy", bus.busy, 0);
        check("rst.waddr", bus.waddr, 0);
        check("rst.wdata", bus.wdata, 0);
        rst = 1'b0;
        #200;

        spi_frame(16, 64'hC35A);
        check_outs("t1");

        spi_frame(16, 64'hFF01);
        check_outs("t2a");
        spi_frame(16, 64'h0080);
        check_outs("t2b");

        spi_frame(16, 64'h3412);
        spi_frame(15, 64'h7FFF);
        check_outs("t3_15");
        spi_frame(17, 64'h1ABCD);
        check_outs("t3_17");

        bus.cs = 1'b0;
        #500;
        send_bits(8, 64'h55);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_addr = 8'h00;
        exp_data = 8'h00;
        #100 rst = 1'b0;
        send_bits(8, 64'hAA);
        #500 bus.cs = 1'b1;
        #1000;
        check_outs("t4_rst");
        spi_frame(16, 64'h3CA5);
        check_outs("t4_next");

        busy_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.sdata = i[0];
            #500 bus.sclk = 1'b1;
            #500 bus.sclk = 1'b0;
        end
        #1000;
        check("t5.busy", busy_seen, 0);
        check_outs("t5");

        bus.cs = 1'b0;
        #500;
        send_bits(16, 64'h9E4D);
        #500;
        check("t6.busy_on", bus.busy, 1);
        @(posedge clk);
        #1 bus.cs = 1'b1;
        lat = 0;
        busy_pre = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) busy_pre = bus.busy;
            if (bus.we) begin
                lat = i;
                break;
            end
        end
        check("t6.latency", lat, 4);
        check("t6.busy_pre", busy_pre, 1);
        check("t6.busy_off", bus.busy, 0);
        @(posedge clk);
        #1 check("t6.we_width", bus.we, 0);
        #1000;
        model_frame(16, 64'h9E4D);
        check_outs("t6");

        for (int k = 0; k < 16; k++) begin
            n = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 36)) : 16;
            bits = {$urandom, $urandom};
            spi_frame(n, bits);
            check_outs($sformatf("rnd%0d", k));
        end

        check("we_pulse_width", we_wide, 0);
        check("err_pulse_width", err_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
